// File: rtl/card_board_store_if.sv
// Card board bus: game-side write port, debounced buttons, selection handshake
// and the display read port, bundled between the game/scanner and the board store.
interface card_board_store_if;
  logic       WriteEnable;
  logic [3:0] dataLoc;
  logic [5:0] dataIn;
  logic       BtnLeft;
  logic       BtnRight;
  logic       BtnUp;
  logic       BtnDown;
  logic       BtnSel;
  logic [3:0] CursorLoc;
  logic       Select;
  logic [5:0] CardSelectData;
  logic [3:0] CardSelectLoc;
  logic       SelReject;
  logic [3:0] RdAddr;
  logic [5:0] RdData;
  logic [4:0] RemovedCount;

  modport master (
    output WriteEnable, dataLoc, dataIn, BtnLeft, BtnRight, BtnUp, BtnDown,
           BtnSel, RdAddr,
    input  CursorLoc, Select, CardSelectData, CardSelectLoc, SelReject,
           RdData, RemovedCount
  );

  modport slave (
    input  WriteEnable, dataLoc, dataIn, BtnLeft, BtnRight, BtnUp, BtnDown,
           BtnSel, RdAddr,
    output CursorLoc, Select, CardSelectData, CardSelectLoc, SelReject,
           RdData, RemovedCount
  );
endinterface

// File: rtl/card_board_store.sv
// Board-side store for the card game: 16-entry board, 4x4 cursor, selection
// handshake with fixed-length Select strobe, removed-card counter and display read port.
module card_board_store #(
  parameter int SEL_HOLD  = 4,
  parameter int NUM_CARDS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  card_board_store_if.slave  bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [1:0] STAT_HIDDEN  = 2'b01;
  localparam logic [1:0] STAT_REMOVED = 2'b10;

  logic [5:0] r_mem [NUM_CARDS];
  logic [5:0] r_rd_data;
  logic [4:0] r_removed_cnt;
  logic [3:0] r_cursor;
  logic [0:0] r_state;
  logic       r_select;
  logic [3:0] r_hold_cnt;
  logic [5:0] r_sel_data;
  logic [3:0] r_sel_loc;
  logic       r_sel_reject;

  logic [5:0] w_old_entry;
  logic [5:0] w_cur_entry;
  logic       w_old_removed;
  logic       w_new_removed;
  logic [4:0] w_removed_next;
  logic [3:0] w_cursor_next;

  assign w_old_entry   = r_mem[bus.dataLoc];
  assign w_cur_entry   = r_mem[r_cursor];
  assign w_old_removed = (w_old_entry[5:4] == STAT_REMOVED);
  assign w_new_removed = (bus.dataIn[5:4] == STAT_REMOVED);

  // Removed counter tracks status transitions into/out of "removed", saturating both ends
  always_comb begin
    w_removed_next = r_removed_cnt;
    if (bus.WriteEnable) begin
      if (!w_old_removed && w_new_removed && (r_removed_cnt != 5'd16)) begin
        w_removed_next = r_removed_cnt + 5'd1;
      end else if (w_old_removed && !w_new_removed && (r_removed_cnt != 5'd0)) begin
        w_removed_next = r_removed_cnt - 5'd1;
      end else begin
        w_removed_next = r_removed_cnt;
      end
    end else begin
      w_removed_next = r_removed_cnt;
    end
  end

  // Cursor moves wrap within the row/column; one pulse per cycle, frozen during Select
  always_comb begin
    w_cursor_next = r_cursor;
    if (r_select) begin
      w_cursor_next = r_cursor;
    end else if (bus.BtnLeft) begin
      w_cursor_next = {r_cursor[3:2], r_cursor[1:0] - 2'd1};
    end else if (bus.BtnRight) begin
      w_cursor_next = {r_cursor[3:2], r_cursor[1:0] + 2'd1};
    end else if (bus.BtnUp) begin
      w_cursor_next = {r_cursor[3:2] - 2'd1, r_cursor[1:0]};
    end else if (bus.BtnDown) begin
      w_cursor_next = {r_cursor[3:2] + 2'd1, r_cursor[1:0]};
    end else begin
      w_cursor_next = r_cursor;
    end
  end

  // Board storage, display read (old data on same-address write) and removed counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CARDS; i++) begin
        r_mem[i] <= 6'b110000;
      end
      r_rd_data     <= 6'd0;
      r_removed_cnt <= 5'd0;
      r_cursor      <= 4'd0;
    end else begin
      if (bus.WriteEnable) begin
        r_mem[bus.dataLoc] <= bus.dataIn;
      end
      r_rd_data     <= r_mem[bus.RdAddr];
      r_removed_cnt <= w_removed_next;
      r_cursor      <= w_cursor_next;
    end
  end

  // Selection handshake; the entry is judged on its pre-write contents
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_select     <= 1'b0;
      r_hold_cnt   <= 4'd0;
      r_sel_data   <= 6'd0;
      r_sel_loc    <= 4'd0;
      r_sel_reject <= 1'b0;
    end else begin
      r_sel_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.BtnSel) begin
            if ((w_cur_entry[5:4] == STAT_HIDDEN) && !bus.WriteEnable) begin
              r_sel_data <= w_cur_entry;
              r_sel_loc  <= r_cursor;
              r_select   <= 1'b1;
              r_hold_cnt <= 4'(SEL_HOLD);
              r_state    <= ST_HOLD;
            end else begin
              r_sel_reject <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == 4'd1) begin
            r_select   <= 1'b0;
            r_hold_cnt <= 4'd0;
            r_state    <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        default: begin
          r_select   <= 1'b0;
          r_hold_cnt <= 4'd0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.CursorLoc      = r_cursor;
  assign bus.Select         = r_select;
  assign bus.CardSelectData = r_sel_data;
  assign bus.CardSelectLoc  = r_sel_loc;
  assign bus.SelReject      = r_sel_reject;
  assign bus.RdData         = r_rd_data;
  assign bus.RemovedCount   = r_removed_cnt;
endmodule

// File: tb/tb_card_board_store.sv
// Directed bench for card_board_store: table of single-cycle vectors with
// hand-computed outputs, plus sequences for saturation and reset during HOLD.
module tb_card_board_store;
  localparam int B_L = 16, B_R = 8, B_U = 4, B_D = 2, B_S = 1;

  typedef struct packed {
    logic       we;
    logic [3:0] loc;
    logic [5:0] din;
    logic [4:0] btn;
    logic [3:0] rd;
    logic [3:0] cur;
    logic       sel;
    logic       rej;
    logic [4:0] rc;
    logic [5:0] rdd;
    logic [5:0] csd;
    logic [3:0] csl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   idx      = 0;
  vec_t vecs [24];
  logic [15:0] rem_model;
  int   exp_rc;

  card_board_store_if bus_if ();

  card_board_store #(.SEL_HOLD(4), .NUM_CARDS(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int we, int loc, int din, int btn, int rd,
                              int cur, int sel, int rej, int rc, int rdd,
                              int csd, int csl);
    vec_t v;
    v.we = 1'(we);    v.loc = 4'(loc); v.din = 6'(din); v.btn = 5'(btn);
    v.rd = 4'(rd);    v.cur = 4'(cur); v.sel = 1'(sel); v.rej = 1'(rej);
    v.rc = 5'(rc);    v.rdd = 6'(rdd); v.csd = 6'(csd); v.csl = 4'(csl);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic step(input logic r, input logic we, input logic [3:0] loc,
                      input logic [5:0] din, input logic [4:0] btn, input logic [3:0] rd);
    rst                = r;
    bus_if.WriteEnable = we;
    bus_if.dataLoc     = loc;
    bus_if.dataIn      = din;
    bus_if.BtnLeft     = btn[4];
    bus_if.BtnRight    = btn[3];
    bus_if.BtnUp       = btn[2];
    bus_if.BtnDown     = btn[1];
    bus_if.BtnSel      = btn[0];
    bus_if.RdAddr      = rd;
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic chk_all(input int cur, input int sel, input int rej, input int rc,
                         input int rdd, input int csd, input int csl);
    chk("cursor",   32'(bus_if.CursorLoc),      32'(cur));
    chk("select",   32'(bus_if.Select),         32'(sel));
    chk("reject",   32'(bus_if.SelReject),      32'(rej));
    chk("removed",  32'(bus_if.RemovedCount),   32'(rc));
    chk("rddata",   32'(bus_if.RdData),         32'(rdd));
    chk("seldata",  32'(bus_if.CardSelectData), 32'(csd));
    chk("selloc",   32'(bus_if.CardSelectLoc),  32'(csl));
  endtask

  initial begin
    // Selection of hidden loc 5, Select held 4 cycles, write to latched entry ignored
    vecs[0]  = mk(1, 5, 'b010011, 0,       5, 0, 0, 0, 0, 'b110000, 0, 0);
    vecs[1]  = mk(0, 0, 0,        B_R,     5, 1, 0, 0, 0, 'b010011, 0, 0);
    vecs[2]  = mk(0, 0, 0,        B_D,     0, 5, 0, 0, 0, 'b110000, 0, 0);
    vecs[3]  = mk(0, 0, 0,        B_S,     0, 5, 1, 0, 0, 'b110000, 'b010011, 5);
    vecs[4]  = mk(1, 5, 'b010000, B_L,     5, 5, 1, 0, 0, 'b010011, 'b010011, 5);
    vecs[5]  = mk(0, 0, 0,        B_S,     5, 5, 1, 0, 0, 'b010000, 'b010011, 5);
    vecs[6]  = mk(0, 0, 0,        0,       0, 5, 1, 0, 0, 'b110000, 'b010011, 5);
    vecs[7]  = mk(0, 0, 0,        0,       0, 5, 0, 0, 0, 'b110000, 'b010011, 5);
    // Shown card at loc 2 is refused
    vecs[8]  = mk(1, 2, 'b000111, 0,       2, 5, 0, 0, 0, 'b110000, 'b010011, 5);
    vecs[9]  = mk(0, 0, 0,        B_U,     2, 1, 0, 0, 0, 'b000111, 'b010011, 5);
    vecs[10] = mk(0, 0, 0,        B_R,     0, 2, 0, 0, 0, 'b110000, 'b010011, 5);
    vecs[11] = mk(0, 0, 0,        B_S,     0, 2, 0, 1, 0, 'b110000, 'b010011, 5);
    vecs[12] = mk(0, 0, 0,        0,       0, 2, 0, 0, 0, 'b110000, 'b010011, 5);
    // Cursor wrap and priority
    vecs[13] = mk(0, 0, 0,        B_L,     0, 1, 0, 0, 0, 'b110000, 'b010011, 5);
    vecs[14] = mk(0, 0, 0,        B_L,     0, 0, 0, 0, 0, 'b110000, 'b010011, 5);
    vecs[15] = mk(0, 0, 0,        B_L,     0, 3, 0, 0, 0, 'b110000, 'b010011, 5);
    vecs[16] = mk(0, 0, 0,        B_U,     0, 15, 0, 0, 0, 'b110000, 'b010011, 5);
    vecs[17] = mk(0, 0, 0,        B_D,     0, 3, 0, 0, 0, 'b110000, 'b010011, 5);
    vecs[18] = mk(0, 0, 0,        B_L|B_D, 0, 2, 0, 0, 0, 'b110000, 'b010011, 5);
    // Removed counter up/up/down
    vecs[19] = mk(1, 9, 'b100001, 0,       9, 2, 0, 0, 1, 'b110000, 'b010011, 5);
    vecs[20] = mk(1, 10, 'b100001, 0,      9, 2, 0, 0, 2, 'b100001, 'b010011, 5);
    vecs[21] = mk(1, 9, 'b010001, 0,      10, 2, 0, 0, 1, 'b100001, 'b010011, 5);
    // Read-during-write returns old data
    vecs[22] = mk(1, 7, 'b011010, 0,       7, 2, 0, 0, 1, 'b110000, 'b010011, 5);
    vecs[23] = mk(0, 0, 0,        0,       7, 2, 0, 0, 1, 'b011010, 'b010011, 5);

    step(1'b1, 1'b0, 4'd0, 6'd0, 5'd0, 4'd0);
    step(1'b1, 1'b1, 4'd3, 6'b100000, 5'b11111, 4'd3);
    chk_all(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      step(1'b0, vecs[i].we, vecs[i].loc, vecs[i].din, vecs[i].btn, vecs[i].rd);
      chk_all(vecs[i].cur, vecs[i].sel, vecs[i].rej, vecs[i].rc, vecs[i].rdd,
              vecs[i].csd, vecs[i].csl);
    end

    // 17 removed-writes: count climbs to 16 and saturates there
    rem_model = 16'h0400;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 4'(i % 16), 6'b100000, 5'd0, 4'd0);
      rem_model[i % 16] = 1'b1;
      exp_rc = $countones(rem_model);
      chk("sat_removed", 32'(bus_if.RemovedCount), 32'(exp_rc));
    end
    chk("sat_final", 32'(bus_if.RemovedCount), 32'd16);

    // Hidden card at 0, reject while writing, accept, then reset in HOLD
    step(1'b0, 1'b1, 4'd0, 6'b010101, 5'(B_L), 4'd0);
    chk("hs_cursor1", 32'(bus_if.CursorLoc), 32'd1);
    chk("hs_removed", 32'(bus_if.RemovedCount), 32'd15);
    step(1'b0, 1'b0, 4'd0, 6'd0, 5'(B_L), 4'd0);
    chk("hs_cursor0", 32'(bus_if.CursorLoc), 32'd0);
    step(1'b0, 1'b1, 4'd1, 6'b100000, 5'(B_S), 4'd0);
    chk("wr_reject", 32'(bus_if.SelReject), 32'd1);
    chk("wr_nosel",  32'(bus_if.Select), 32'd0);
    chk("wr_removed", 32'(bus_if.RemovedCount), 32'd15);
    step(1'b0, 1'b0, 4'd0, 6'd0, 5'(B_S), 4'd0);
    chk("hs_select", 32'(bus_if.Select), 32'd1);
    chk("hs_data",   32'(bus_if.CardSelectData), 32'b010101);
    chk("hs_loc",    32'(bus_if.CardSelectLoc), 32'd0);
    chk("hs_norej",  32'(bus_if.SelReject), 32'd0);
    step(1'b0, 1'b0, 4'd0, 6'd0, 5'd0, 4'd0);
    chk("hs_hold2", 32'(bus_if.Select), 32'd1);
    step(1'b1, 1'b0, 4'd0, 6'd0, 5'd0, 4'd0);
    chk_all(0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 4'd0, 6'd0, 5'd0, 4'd3);
    chk("rst_rd3", 32'(bus_if.RdData), 32'b110000);
    step(1'b0, 1'b0, 4'd0, 6'd0, 5'd0, 4'd0);
    chk("rst_rd0", 32'(bus_if.RdData), 32'b110000);
    chk("rst_sel", 32'(bus_if.Select), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/card_board_store.md
Name: card_board_store

Overview:
- Board-side end of the card write interface driven by the game state machine.
- Holds the 16-entry card board written through WriteEnable/dataLoc/data, and owns the 4x4 player cursor.
- Turns debounced button pulses into the Select / CardSelectData / CardSelectLoc handshake the game consumes.
- Provides a registered read port for the VGA/display scanner.

Parameters:
- SEL_HOLD, 4, number of cycles Select stays high per accepted selection (range 1..15).
- NUM_CARDS, 16, board entries; fixed 4x4 grid, address width 4.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- WriteEnable  in  1  write strobe from game state machine.
- dataLoc  in  4  write address (row = [3:2], column = [1:0]).
- dataIn  in  6  write data: [5:4] status (00 shown, 01 hidden, 10 removed, 11 empty), [3:0] card value.
- BtnLeft, BtnRight, BtnUp, BtnDown  in  1 each  debounced single-cycle cursor pulses.
- BtnSel  in  1  debounced single-cycle select pulse.
- CursorLoc  out  4  current cursor address.
- Select  out  1  selection strobe to game.
- CardSelectData  out  6  latched entry contents at the accepted selection.
- CardSelectLoc  out  4  latched address of the accepted selection.
- SelReject  out  1  one-cycle pulse when BtnSel is refused.
- RdAddr  in  4  display read address.
- RdData  out  6  display read data.
- RemovedCount  out  5  number of entries whose status is 10 (0..16).

Behaviour:
- Reset: every entry = 6'b110000 (empty); CursorLoc = 0; Select = 0; CardSelectData = 0; CardSelectLoc = 0; SelReject = 0; RdData = 0; RemovedCount = 0; hold counter = 0. Reset dominates all other inputs.
- Write:
  - When WriteEnable is high, mem[dataLoc] <= dataIn at the clock edge.
  - Writes are accepted every cycle, back-to-back, with no handshake.
- Read port:
  - RdData <= mem[RdAddr], 1-cycle latency.
  - When a read and a write hit the same address in the same cycle, RdData returns the old data; the new data is visible from the next read.
- RemovedCount:
  - On each write, +1 if the old status != 10 and the new status == 10.
  - -1 if the old status == 10 and the new status != 10.
  - Otherwise unchanged.
  - Saturates at 16 and at 0; never wraps.
- Cursor (only when Select is low):
  - Left/Right move the column by -1/+1 with wrap inside the row (col 0 Left -> col 3).
  - Up/Down move the row by -1/+1 with wrap inside the column.
  - If several button pulses arrive in one cycle, only one is taken, in priority order Left > Right > Up > Down.
  - While Select is high, cursor pulses are ignored (dropped, not queued).
- Select state machine, two states:
  - IDLE:
    - On BtnSel, evaluate mem[CursorLoc] using pre-write contents (a same-cycle write to that address is not seen).
    - If status == 01 (hidden) and WriteEnable is low: latch CardSelectData <= entry and CardSelectLoc <= CursorLoc, set Select = 1, load the hold counter with SEL_HOLD, go to HOLD.
    - Otherwise (shown, removed, empty, or a write in progress): pulse SelReject for 1 cycle and stay in IDLE.
  - HOLD:
    - Select = 1; the hold counter decrements each cycle.
    - When the counter reaches 1, Select <= 0 on the next edge and the state returns to IDLE.
    - Select is high for exactly SEL_HOLD cycles.
    - BtnSel in HOLD is ignored, with no SelReject.
  - Latency: BtnSel at edge N gives Select high from edge N+1.
  - CardSelectData/CardSelectLoc stay stable from the accept edge until the next accepted selection, including after Select falls.
  - Writes to the latched entry during HOLD do not alter CardSelectData.
- Reset mid-HOLD: Select drops on the reset edge; the board is cleared to empty.

Test Plan:
- Reset, then write loc 5 = 6'b010011, cursor to 5 (Right ×1, Down ×1), BtnSel -> Select high 4 cycles starting the next edge, CardSelectData = 6'b010011, CardSelectLoc = 5, SelReject = 0.
- Write loc 2 = 6'b000111 (shown), cursor to 2, BtnSel -> SelReject 1-cycle pulse, Select stays 0, latched outputs unchanged.
- Cursor at 0: Left -> 3, Up -> 15, Down -> 3; Left and Down in the same cycle from 3 -> 2 only.
- Write loc 9 = 6'b100001, then loc 10 = 6'b100001, then loc 9 = 6'b010001 -> RemovedCount 1, 2, 1; 17 removed-writes to distinct or repeat removed entries never exceed 16.
- RdAddr = 7 with a same-cycle write of 6'b011010 to 7 (old value 6'b110000) -> RdData = 6'b110000 next cycle, 6'b011010 the cycle after.
- Accept a selection, assert Reset on HOLD cycle 2 -> Select = 0 next edge, RdData of any address = 6'b110000 after 1 read, CursorLoc = 0.
